// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
package wb_arb_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned MAX_NUM_REQ    = 8;

  // Round-robin pointer following a grant to `winner`.
  function automatic int unsigned rr_next_ptr(input int unsigned winner,
                                              input int unsigned num_req);
    return (winner + 1 >= num_req) ? 0 : winner + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first request at or after the pointer, searching upward
// modulo NUM_REQ. Reusable for any shared single-port resource.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_valid
);

  int unsigned idx;
  logic [IDX_W-1:0] idx_w;

  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_valid  = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(i_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w = IDX_W'(idx);
      if (!o_valid && i_req[idx_w]) begin
        o_valid        = 1'b1;
        o_grant[idx_w] = 1'b1;
        o_winner       = idx_w;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback sources.
// Optional arbitration-loss counter enabled by defining WB_ARB_PERF_EN.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter bit          HARDWIRE_ZERO = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_stall,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*5-1:0]           i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic                           o_write_enable,
  output logic [4:0]                     o_write_addr,
  output logic [DATA_WIDTH-1:0]          o_write_data,
  output logic [31:0]                    o_conflict_count
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AW    = REG_ADDR_WIDTH;

  logic [NUM_REQ-1:0]    live;
  logic [NUM_REQ-1:0]    sink;
  logic [NUM_REQ-1:0]    pick_req;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      winner;
  logic                  any_grant;
  logic [IDX_W-1:0]      ptr_q;
  logic                  we_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // x0 requests are sunk immediately and never compete for the port.
  always_comb begin
    live = '0;
    sink = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (HARDWIRE_ZERO && (i_req_addr[i*AW +: AW] == '0)) begin
        sink[i] = i_req_valid[i];
      end else begin
        live[i] = i_req_valid[i];
      end
    end
  end

  assign pick_req = live & {NUM_REQ{~i_stall}};

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req    (pick_req),
    .i_ptr    (ptr_q),
    .o_grant  (grant),
    .o_winner (winner),
    .o_valid  (any_grant)
  );

  assign o_req_ready = grant | sink;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = i_req_addr[i*AW +: AW];
        sel_data = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ptr_q  <= '0;
    end else if (!i_stall) begin
      we_q <= any_grant;
      if (any_grant) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
        ptr_q  <= IDX_W'(rr_next_ptr(32'(winner), NUM_REQ));
      end
    end
  end

  assign o_write_enable = we_q;
  assign o_write_addr   = addr_q;
  assign o_write_data   = data_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] conflict_q;
  logic [3:0]  num_live;
  logic [32:0] conflict_sum;

  always_comb begin
    num_live = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      num_live = num_live + 4'(live[i]);
    end
    conflict_sum = {1'b0, conflict_q} + 33'(num_live) - 33'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      conflict_q <= '0;
    end else if (!i_stall && (num_live >= 4'd2)) begin
      conflict_q <= conflict_sum[32] ? '1 : conflict_sum[31:0];
    end
  end

  assign o_conflict_count = conflict_q;
`else
  assign o_conflict_count = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus pushes expected writes, a monitor
// pops and compares each write committed on the port.
module tb_regfile_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall = 1'b0;
  logic [3:0]   v = '0;
  logic [4:0]   a [4];
  logic [31:0]  d [4];
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   ready;
  logic         we;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic [31:0]  cnt;

  logic [1:0]   b_valid = '0;
  logic [9:0]   b_addr = '0;
  logic [127:0] b_data = '0;
  logic [1:0]   b_ready;
  logic         b_we;
  logic [4:0]   b_waddr;
  logic [63:0]  b_wdata;
  logic [31:0]  b_cnt;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q [$];
  logic [31:0] rf [32];
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_addr[i*5 +: 5]   = a[i];
      req_data[i*32 +: 32] = d[i];
    end
  end

  regfile_wb_arbiter u_dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stall          (stall),
    .i_req_valid      (v),
    .i_req_addr       (req_addr),
    .i_req_data       (req_data),
    .o_req_ready      (ready),
    .o_write_enable   (we),
    .o_write_addr     (waddr),
    .o_write_data     (wdata),
    .o_conflict_count (cnt)
  );

  regfile_wb_arbiter #(
    .NUM_REQ       (2),
    .DATA_WIDTH    (64),
    .HARDWIRE_ZERO (1'b0)
  ) u_dut64 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stall          (1'b0),
    .i_req_valid      (b_valid),
    .i_req_addr       (b_addr),
    .i_req_data       (b_data),
    .o_req_ready      (b_ready),
    .o_write_enable   (b_we),
    .o_write_addr     (b_waddr),
    .o_write_data     (b_wdata),
    .o_conflict_count (b_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input logic [4:0] ad, input logic [31:0] da);
    wr_t w;
    w.addr = ad;
    w.data = da;
    exp_q.push_back(w);
  endtask

  // Entered at posedge+1 with inputs set; checks ready, then sources drop accepted requests.
  task automatic tick(input logic [3:0] exp_rdy, input string nm);
    logic [3:0] acc;
    #1;
    chk(nm, 64'(ready), 64'(exp_rdy));
    acc = v & ready;
    @(posedge clk);
    #1;
    v = v & ~acc;
  endtask

  // A write commits on the port at each unstalled edge while enable is high.
  always @(negedge clk) begin
    if (!rst && we && !stall) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(waddr), 64'h0);
        checks++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", waddr, wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 64'(waddr), 64'(w.addr));
        chk("wr_data", 64'(wdata), 64'(w.data));
        rf[waddr] = wdata;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    for (int i = 0; i < 32; i++) rf[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(we), 64'h0);
    chk("rst_addr", 64'(waddr), 64'h0);
    chk("rst_data", 64'(wdata), 64'h0);
    chk("rst_cnt", 64'(cnt), 64'h0);
    chk("rst_b_we", 64'(b_we), 64'h0);
    rst = 1'b0;

    // Reset mid-write discards the in-flight write and the pointer.
    v = 4'b0010; a[1] = 5'd7; d[1] = 32'h77;
    tick(4'b0010, "rdy_pre_rst");
    chk("pre_rst_we", 64'(we), 64'h1);
    chk("pre_rst_addr", 64'(waddr), 64'd7);
    rst = 1'b1;
    #1;
    chk("async_rst_we", 64'(we), 64'h0);
    chk("async_rst_addr", 64'(waddr), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    v = 4'b0101; a[0] = 5'd3; d[0] = 32'h33; a[2] = 5'd8; d[2] = 32'h88;
    push(5'd3, 32'h33);
    push(5'd8, 32'h88);
    tick(4'b0001, "rdy_after_rst0");
    tick(4'b0100, "rdy_after_rst2");
    tick(4'b0000, "idle0");
    tick(4'b0000, "idle1");

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All four live: RR order 0,1,2,3.
    v = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      a[i] = 5'(i + 1);
      d[i] = 32'h100 + 32'(i);
    end
    push(5'd1, 32'h100);
    push(5'd2, 32'h101);
    push(5'd3, 32'h102);
    push(5'd4, 32'h103);
    tick(4'b0001, "rr_g0");
    tick(4'b0010, "rr_g1");
    tick(4'b0100, "rr_g2");
    tick(4'b1000, "rr_g3");
`ifdef WB_ARB_PERF_EN
    chk("conflict_cnt", 64'(cnt), 64'd6);
`else
    chk("conflict_cnt", 64'(cnt), 64'd0);
`endif

    // Zero sink: sources 1,2 to x0, source 3 to addr 5.
    v = 4'b1110; a[1] = 5'd0; a[2] = 5'd0; a[3] = 5'd5; d[3] = 32'h55;
    push(5'd5, 32'h55);
    tick(4'b1110, "zero_sink_rdy");
    tick(4'b0000, "zero_idle");

    // Stall hold: pointer back at 0 so source 0 wins.
    v = 4'b0001; a[0] = 5'd9; d[0] = 32'hDEADBEEF;
    push(5'd9, 32'hDEADBEEF);
    tick(4'b0001, "stall_pre_rdy");
    stall = 1'b1;
    v = 4'b0110; a[1] = 5'd0; a[2] = 5'd10; d[2] = 32'hA;
    tick(4'b0010, "stall_sink_rdy");
    tick(4'b0000, "stall_rdy1");
    tick(4'b0000, "stall_rdy2");
    chk("stall_we", 64'(we), 64'h1);
    chk("stall_addr", 64'(waddr), 64'd9);
    chk("stall_data", 64'(wdata), 64'hDEADBEEF);
    stall = 1'b0;
    push(5'd10, 32'hA);
    tick(4'b0100, "unstall_rdy");
    chk("unstall_addr", 64'(waddr), 64'd10);
    tick(4'b0000, "idle2");
    tick(4'b0000, "idle3");

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Same destination from two sources: RR order decides the final value.
    v = 4'b0011; a[0] = 5'd6; d[0] = 32'h11; a[1] = 5'd6; d[1] = 32'h22;
    push(5'd6, 32'h11);
    push(5'd6, 32'h22);
    tick(4'b0001, "same_g0");
    tick(4'b0010, "same_g1");
    tick(4'b0000, "idle4");
    tick(4'b0000, "idle5");
    chk("rf_addr6", 64'(rf[6]), 64'h22);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("final_we", 64'(we), 64'h0);

    // 64-bit instance without hardwired zero: x0 uses the port.
    b_valid = 2'b01; b_addr = '0; b_data = '0; b_data[63:0] = 64'h1;
    #1;
    chk("b_rdy", 64'(b_ready), 64'h1);
    @(posedge clk);
    #1;
    b_valid = '0;
    chk("b_we", 64'(b_we), 64'h1);
    chk("b_addr", 64'(b_waddr), 64'h0);
    chk("b_data", b_wdata, 64'h1);
    chk("b_cnt", 64'(b_cnt), 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
